// File: rtl/break_watch_unit_pkg.sv
// Shared mode/state encodings and helpers for the break/watch unit.
// Hit counters exist only when BREAK_HITCNT_EN is defined.
package break_watch_unit_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_EXEC   = 2'd1,
    MODE_DREAD  = 2'd2,
    MODE_DWRITE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/break_watch_unit_if.sv
// CPU-side observation bundle: executing PC and data bus strobes.
// master drives the bundle, slave (a channel) only observes it.
interface break_watch_unit_if #(
  parameter int XLEN = 64
);
  logic [XLEN-1:0] pc;
  logic            instr_valid;
  logic            dre;
  logic            dwe;
  logic [XLEN-1:0] daddr;

  modport master (
    output pc, instr_valid, dre, dwe, daddr
  );

  modport slave (
    input pc, instr_valid, dre, dwe, daddr
  );
endinterface

// File: rtl/break_watch_unit_channel.sv
// break_channel: one break/watch channel (config regs, comparators,
// optional saturating hit counter under BREAK_HITCNT_EN).
module break_channel
  import break_watch_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  break_watch_unit_if.slave    bus,
  input  logic                 exec_en,
  input  logic                 cnt_en,
  input  logic                 cfg_we,
  input  mode_e                cfg_mode,
  input  logic [XLEN-1:0]      cfg_addr,
  output logic                 hit_o,
  output logic [CNT_W-1:0]     cnt_o
);

  mode_e           mode_q, mode_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            exec_m;
  logic            dword_m;
  logic            unused_lo;

  always_comb begin
    mode_d = mode_q;
    addr_d = addr_q;
    if (cfg_we) begin
      mode_d = cfg_mode;
      addr_d = cfg_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_OFF;
      addr_q <= '0;
    end else begin
      mode_q <= mode_d;
      addr_q <= addr_d;
    end
  end

  // Data watches match on the whole doubleword.
  assign exec_m  = (bus.pc == addr_q);
  assign dword_m = (bus.daddr[XLEN-1:3] == addr_q[XLEN-1:3]);
  assign unused_lo = ^bus.daddr[2:0];

  always_comb begin
    hit_o = 1'b0;
    unique case (mode_q)
      MODE_OFF:    hit_o = 1'b0;
      MODE_EXEC:   hit_o = bus.instr_valid & exec_en & exec_m;
      MODE_DREAD:  hit_o = bus.dre & dword_m;
      MODE_DWRITE: hit_o = bus.dwe & dword_m;
      default:     hit_o = 1'b0;
    endcase
  end

`ifdef BREAK_HITCNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A config write restarts the count, even on a hit cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_we) begin
      cnt_d = '0;
    end else if (cnt_en && hit_o) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
`else
  logic unused_cnt_en;
  assign unused_cnt_en = cnt_en;
  assign cnt_o = '0;
`endif

endmodule

// File: rtl/break_watch_unit.sv
// Break/watch unit: NCH channels, RUN/HALT/STEP halt controller.
// Optional per-channel hit counters under BREAK_HITCNT_EN.
module break_watch_unit
  import break_watch_unit_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NCH  = 4
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic [XLEN-1:0] iPC,
  input  logic            iInstrValid,
  input  logic            iDReadEnable,
  input  logic            iDWriteEnable,
  input  logic [XLEN-1:0] iDAddress,
  input  logic            iCfgWe,
  input  logic [2:0]      iCfgIdx,
  input  logic [1:0]      iCfgMode,
  input  logic [XLEN-1:0] iCfgAddr,
  input  logic            iResume,
  input  logic            iStep,
  output logic            oBreak,
  output logic [NCH-1:0]  oHitMask,
  output logic [15:0]     oHitCount,
  output logic [1:0]      oState
);

  break_watch_unit_if #(.XLEN(XLEN)) bus ();

  assign bus.pc          = iPC;
  assign bus.instr_valid = iInstrValid;
  assign bus.dre         = iDReadEnable;
  assign bus.dwe         = iDWriteEnable;
  assign bus.daddr       = iDAddress;

  state_e          state_q, state_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [XLEN-1:0] hpc_q, hpc_d;
  logic            sup_q, sup_d;
  logic [NCH-1:0]  hits;
  logic            exec_en;
  logic            cnt_en;
  logic [15:0]     cnt [NCH];

  // Right after leaving HALT, the halted PC must not re-break.
  assign exec_en = !(sup_q && (iPC == hpc_q));
  assign cnt_en  = (state_q != ST_HALT);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic sel;
    assign sel = iCfgWe && (iCfgIdx == 3'(i));
    break_channel #(.XLEN(XLEN)) u_ch (
      .clk      (iCLK),
      .rst_n    (iRST),
      .bus      (bus),
      .exec_en  (exec_en),
      .cnt_en   (cnt_en),
      .cfg_we   (sel),
      .cfg_mode (mode_e'(iCfgMode)),
      .cfg_addr (iCfgAddr),
      .hit_o    (hits[i]),
      .cnt_o    (cnt[i])
    );
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q <= ST_RUN;
      mask_q  <= '0;
      hpc_q   <= '0;
      sup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      hpc_q   <= hpc_d;
      sup_q   <= sup_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (|hits) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (iStep)        state_d = ST_STEP;
        else if (iResume) state_d = ST_RUN;
      end
      ST_STEP: begin
        if (iInstrValid) state_d = ST_HALT;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    mask_d = mask_q;
    hpc_d  = hpc_q;
    sup_d  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (|hits) begin
          mask_d = hits;
          hpc_d  = iPC;
        end
      end
      ST_HALT: begin
        if (iStep || iResume) begin
          mask_d = '0;
          sup_d  = 1'b1;
        end
      end
      ST_STEP: begin
        if (iInstrValid) begin
          mask_d = hits;
          hpc_d  = iPC;
        end
      end
      default: mask_d = '0;
    endcase
  end

  always_comb begin
    oBreak   = (state_q == ST_HALT);
    oState   = state_q;
    oHitMask = mask_q;
  end

  always_comb begin
    oHitCount = '0;
    for (int i = 0; i < NCH; i++) begin
      if (iCfgIdx == 3'(i)) oHitCount = cnt[i];
    end
  end

endmodule

// File: tb/tb_break_watch_unit.sv
// Self-checking bench for break_watch_unit: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_break_watch_unit;

  localparam int XLEN = 64;
  localparam int NCH  = 4;

  logic            iCLK = 1'b0;
  logic            iRST;
  logic            iCfgWe;
  logic [2:0]      iCfgIdx;
  logic [1:0]      iCfgMode;
  logic [XLEN-1:0] iCfgAddr;
  logic            iResume;
  logic            iStep;
  logic            oBreak;
  logic [NCH-1:0]  oHitMask;
  logic [15:0]     oHitCount;
  logic [1:0]      oState;

  break_watch_unit_if #(.XLEN(XLEN)) cpu ();

  break_watch_unit #(.XLEN(XLEN), .NCH(NCH)) dut (
    .iCLK          (iCLK),
    .iRST          (iRST),
    .iPC           (cpu.pc),
    .iInstrValid   (cpu.instr_valid),
    .iDReadEnable  (cpu.dre),
    .iDWriteEnable (cpu.dwe),
    .iDAddress     (cpu.daddr),
    .iCfgWe        (iCfgWe),
    .iCfgIdx       (iCfgIdx),
    .iCfgMode      (iCfgMode),
    .iCfgAddr      (iCfgAddr),
    .iResume       (iResume),
    .iStep         (iStep),
    .oBreak        (oBreak),
    .oHitMask      (oHitMask),
    .oHitCount     (oHitCount),
    .oState        (oState)
  );

  always #5 iCLK = ~iCLK;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Model: state 0=run 1=halt 2=step
  int             m_state;
  logic [NCH-1:0] m_mask;
  int             m_mode [NCH];
  logic [63:0]    m_addr [NCH];
  int             m_cnt  [NCH];
  logic [63:0]    m_hpc;
  bit             m_sup;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_mask  = '0;
    m_hpc   = '0;
    m_sup   = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      m_mode[c] = 0;
      m_addr[c] = '0;
      m_cnt[c]  = 0;
    end
  endtask

  task automatic model_step();
    logic [NCH-1:0] h;
    bit nsup;
    h = '0;
    if (m_state != 1) begin
      for (int c = 0; c < NCH; c++) begin
        case (m_mode[c])
          1: h[c] = cpu.instr_valid && cpu.pc == m_addr[c]
                    && !(m_sup && cpu.pc == m_hpc);
          2: h[c] = cpu.dre && (cpu.daddr >> 3) == (m_addr[c] >> 3);
          3: h[c] = cpu.dwe && (cpu.daddr >> 3) == (m_addr[c] >> 3);
          default: h[c] = 1'b0;
        endcase
`ifdef BREAK_HITCNT_EN
        if (h[c] && m_cnt[c] < 65535) m_cnt[c]++;
`endif
      end
    end
    if (iCfgWe && iCfgIdx < NCH) begin
      m_mode[iCfgIdx] = int'(iCfgMode);
      m_addr[iCfgIdx] = iCfgAddr;
      m_cnt[iCfgIdx]  = 0;
    end
    nsup = 1'b0;
    case (m_state)
      0: if (h != 0) begin
        m_state = 1; m_mask = h; m_hpc = cpu.pc;
      end
      1: if (iStep) begin
        m_state = 2; m_mask = '0; nsup = 1'b1;
      end else if (iResume) begin
        m_state = 0; m_mask = '0; nsup = 1'b1;
      end
      default: if (cpu.instr_valid) begin
        m_state = 1; m_mask = h; m_hpc = cpu.pc;
      end
    endcase
    m_sup = nsup;
  endtask

  always @(negedge iCLK) begin
    if (cmp_en && iRST) begin
      int ec;
      ec = 0;
`ifdef BREAK_HITCNT_EN
      if (iCfgIdx < NCH) ec = m_cnt[iCfgIdx];
`endif
      chk("cmp_break", 64'(oBreak), 64'(m_state == 1));
      chk("cmp_state", 64'(oState), 64'(m_state));
      chk("cmp_mask", 64'(oHitMask), 64'(m_mask));
      chk("cmp_count", 64'(oHitCount), 64'(ec));
    end
  end

  task automatic set_idle();
    cpu.pc = '0; cpu.instr_valid = 0;
    cpu.dre = 0; cpu.dwe = 0; cpu.daddr = '0;
    iCfgWe = 0; iCfgIdx = '0; iCfgMode = '0; iCfgAddr = '0;
    iResume = 0; iStep = 0;
  endtask

  task automatic tick();
    @(posedge iCLK);
    model_step();
    #1;
  endtask

  task automatic cfg(input int idx, input int md,
                     input logic [63:0] a);
    iCfgWe = 1; iCfgIdx = 3'(idx);
    iCfgMode = 2'(md); iCfgAddr = a;
    tick();
    iCfgWe = 0;
  endtask

  task automatic resume();
    set_idle();
    iResume = 1;
    tick();
    iResume = 0;
  endtask

  logic [63:0] pool [6];

  initial begin
    pool = '{64'h400010, 64'h400014, 64'h10010008,
             64'h10010010, 64'h500000, 64'h0};
    set_idle();
    model_reset();
    iRST = 1;
    #1 iRST = 0;
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_break", 64'(oBreak), 64'd0);
    chk("rst_state", 64'(oState), 64'd0);
    chk("rst_mask", 64'(oHitMask), 64'd0);
    chk("rst_count", 64'(oHitCount), 64'd0);
    iRST = 1;
    cmp_en = 1;

    // exec break
    cfg(0, 1, 64'h400010);
    cpu.instr_valid = 1; cpu.pc = 64'h400010;
    tick();
    chk("exec_break", 64'(oBreak), 64'd1);
    chk("exec_mask", 64'(oHitMask), 64'h1);
    chk("exec_state", 64'(oState), 64'd1);

    // resume on the same PC: no re-break
    iResume = 1;
    tick();
    iResume = 0;
    chk("resume_state", 64'(oState), 64'd0);
    tick();
    chk("no_rebreak", 64'(oState), 64'd0);
    cpu.pc = 64'h400014;
    tick();
    chk("adv_state", 64'(oState), 64'd0);
    cpu.pc = 64'h400010;
    tick();
    chk("rebreak_state", 64'(oState), 64'd1);
    chk("rebreak_mask", 64'(oHitMask), 64'h1);
    resume();
    set_idle();
    tick();

    // dwrite watch, doubleword match
    cfg(1, 3, 64'h10010008);
    cpu.dwe = 1; cpu.daddr = 64'h1001000C;
    tick();
    chk("dw_state", 64'(oState), 64'd1);
    chk("dw_mask", 64'(oHitMask), 64'h2);
    resume();
    cpu.dre = 1; cpu.daddr = 64'h1001000C;
    tick();
    chk("dr_nohit", 64'(oState), 64'd0);
    set_idle();

    // step wins over resume
    cpu.instr_valid = 1; cpu.pc = 64'h400010;
    tick();
    chk("pre_step", 64'(oState), 64'd1);
    set_idle();
    iStep = 1; iResume = 1;
    tick();
    iStep = 0; iResume = 0;
    chk("step_state", 64'(oState), 64'd2);
    chk("step_break", 64'(oBreak), 64'd0);
    chk("step_mask", 64'(oHitMask), 64'd0);
    tick();
    chk("step_wait", 64'(oState), 64'd2);
    cpu.instr_valid = 1; cpu.pc = 64'h400100;
    tick();
    chk("step_halt", 64'(oState), 64'd1);
    chk("step_mask0", 64'(oHitMask), 64'd0);
    set_idle();

    // async reset mid-cycle while halted
    #2 iRST = 0;
    model_reset();
    #1;
    chk("arst_break", 64'(oBreak), 64'd0);
    chk("arst_state", 64'(oState), 64'd0);
    chk("arst_mask", 64'(oHitMask), 64'd0);
    @(posedge iCLK);
    #1 iRST = 1;
    cpu.instr_valid = 1; cpu.pc = 64'h400010;
    cpu.dwe = 1; cpu.daddr = 64'h1001000C;
    tick();
    chk("off_nohit", 64'(oState), 64'd0);
    cpu.pc = 64'h0; cpu.daddr = 64'h0;
    tick();
    chk("off_zero", 64'(oState), 64'd0);
    set_idle();

    // out-of-range channel index ignored
    cfg(5, 1, 64'h600000);
    cpu.instr_valid = 1; cpu.pc = 64'h600000;
    tick();
    chk("idx_oor", 64'(oState), 64'd0);

    // same-cycle config takes effect next cycle
    iCfgWe = 1; iCfgIdx = 3'd0;
    iCfgMode = 2'd1; iCfgAddr = 64'h700000;
    cpu.pc = 64'h700000;
    tick();
    iCfgWe = 0;
    chk("cfg_same", 64'(oState), 64'd0);
    tick();
    chk("cfg_next", 64'(oState), 64'd1);
    resume();
    set_idle();
    tick();

    // hit counter on ch2
    cfg(2, 1, 64'h500000);
    for (int k = 0; k < 3; k++) begin
      cpu.instr_valid = 1; cpu.pc = 64'h500000;
      tick();
      resume();
      set_idle();
      tick();
    end
    iCfgIdx = 3'd2;
    #1;
`ifdef BREAK_HITCNT_EN
    chk("cnt_three", 64'(oHitCount), 64'd3);
`else
    chk("cnt_tied0", 64'(oHitCount), 64'd0);
`endif
    cfg(2, 1, 64'h500000);
    iCfgIdx = 3'd2;
    #1;
    chk("cnt_clear", 64'(oHitCount), 64'd0);
    set_idle();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      set_idle();
      cpu.pc = pool[$urandom_range(0, 5)];
      cpu.instr_valid = ($urandom_range(0, 1) == 1);
      cpu.daddr = pool[$urandom_range(0, 5)]
                  + 64'($urandom_range(0, 15));
      cpu.dre = ($urandom_range(0, 3) == 0);
      cpu.dwe = ($urandom_range(0, 3) == 0);
      iCfgIdx = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin
        iCfgWe = 1;
        iCfgMode = 2'($urandom_range(0, 3));
        iCfgAddr = pool[$urandom_range(0, 5)];
      end
      iResume = ($urandom_range(0, 4) == 0);
      iStep = ($urandom_range(0, 6) == 0);
      tick();
    end

    set_idle();
    @(negedge iCLK);
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
